// File: rtl/aer_output_decoder_if.sv
// AER address-event link between the SNN core (requester) and the output decoder.
// 4-phase REQ/ACK; ADDR is held stable while REQ is high.
interface aer_output_decoder_if #(
    parameter int ADDR_BITS = 8
);
    logic [ADDR_BITS-1:0] addr;
    logic                 req;
    logic                 ack;

    modport master (
        output addr,
        output req,
        input  ack
    );

    modport slave (
        input  addr,
        input  req,
        output ack
    );
endinterface

// File: rtl/aer_output_decoder.sv
// AER receiver at the network output: ACKs every event and counts spikes per class.
// The first class to reach SPIKE_THRESHOLD wins; a RUN timeout ends with NO_WINNER.
module aer_output_decoder #(
    parameter int N_CLASSES       = 10,
    parameter int ADDR_BITS       = 8,
    parameter int CLASS_BASE      = 0,
    parameter int SPIKE_THRESHOLD = 1,
    parameter int CNT_BITS        = 8,
    parameter int TIMEOUT_CYCLES  = 50000,
    localparam int CLS_BITS = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    aer_output_decoder_if.slave aer,
    output logic [CLS_BITS-1:0] o_class_out,
    output logic                o_done,
    output logic                o_no_winner,
    output logic [CNT_BITS-1:0] o_event_cnt
);

    localparam int TMR_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_BITS:0] ADDR_LO =
        (ADDR_BITS+1)'(CLASS_BASE);
    localparam logic [ADDR_BITS:0] ADDR_HI =
        (ADDR_BITS+1)'(CLASS_BASE + N_CLASSES);
    localparam logic [CNT_BITS-1:0] THR = CNT_BITS'(SPIKE_THRESHOLD);
    localparam logic [TMR_BITS-1:0] TMR_LAST =
        TMR_BITS'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        HS_IDLE,
        HS_ACK
    } hs_state_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } inf_state_t;

    logic                 r_req_s1;
    logic                 r_req_s2;
    hs_state_t            r_hs_state;
    hs_state_t            w_hs_next;
    logic                 r_ack;
    logic                 w_ack_next;
    logic                 r_ev_valid;
    logic                 w_capture;
    logic [ADDR_BITS-1:0] r_addr_q;

    inf_state_t           r_state;
    inf_state_t           w_state_next;
    logic [CNT_BITS-1:0]  r_cnt [N_CLASSES];
    logic [CNT_BITS-1:0]  r_event_cnt;
    logic [TMR_BITS-1:0]  r_timer;
    logic [CLS_BITS-1:0]  r_class;
    logic                 r_done;
    logic                 r_no_winner;

    logic                 w_in_range;
    logic [CLS_BITS-1:0]  w_cls;
    logic [CNT_BITS-1:0]  w_cnt_sel;
    logic [CNT_BITS-1:0]  w_cnt_inc;
    logic                 w_hit;
    logic                 w_win;
    logic                 w_tmo;

    // REQ is asynchronous to the clock; only r_req_s2 is used downstream
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_req_s1 <= 1'b0;
            r_req_s2 <= 1'b0;
        end else begin
            r_req_s1 <= aer.req;
            r_req_s2 <= r_req_s1;
        end
    end

    always_comb begin
        w_hs_next  = r_hs_state;
        w_ack_next = r_ack;
        w_capture  = 1'b0;
        unique case (r_hs_state)
            HS_IDLE: begin
                if (r_req_s2) begin
                    w_hs_next  = HS_ACK;
                    w_ack_next = 1'b1;
                    w_capture  = 1'b1;
                end
            end
            HS_ACK: begin
                if (!r_req_s2) begin
                    w_hs_next  = HS_IDLE;
                    w_ack_next = 1'b0;
                end
            end
            default: begin
                w_hs_next  = HS_IDLE;
                w_ack_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hs_state <= HS_IDLE;
            r_ack      <= 1'b0;
            r_ev_valid <= 1'b0;
            r_addr_q   <= '0;
        end else begin
            r_hs_state <= w_hs_next;
            r_ack      <= w_ack_next;
            r_ev_valid <= w_capture;
            if (w_capture) begin
                r_addr_q <= aer.addr;
            end
        end
    end

    // One extra address bit keeps the upper bound from wrapping
    assign w_in_range = ({1'b0, r_addr_q} >= ADDR_LO) &&
                        ({1'b0, r_addr_q} <  ADDR_HI);
    assign w_cls      = CLS_BITS'(r_addr_q - ADDR_BITS'(CLASS_BASE));
    assign w_cnt_sel  = w_in_range ? r_cnt[w_cls] : '0;
    assign w_cnt_inc  = (w_cnt_sel == '1) ? w_cnt_sel
                                          : w_cnt_sel + 1'b1;
    assign w_hit      = (r_state == RUN) && r_ev_valid && w_in_range;
    assign w_win      = w_hit && (w_cnt_inc == THR);
    assign w_tmo      = (r_state == RUN) && (r_timer == TMR_LAST);

    always_comb begin
        w_state_next = r_state;
        if (i_start) begin
            w_state_next = RUN;
        end else begin
            unique case (r_state)
                IDLE:    w_state_next = IDLE;
                RUN:     if (w_win || w_tmo) w_state_next = FIN;
                FIN:     w_state_next = FIN;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < N_CLASSES; i++) r_cnt[i] <= '0;
            r_event_cnt <= '0;
            r_timer     <= '0;
            r_class     <= '0;
            r_done      <= 1'b0;
            r_no_winner <= 1'b0;
        end else if (i_start) begin
            for (int i = 0; i < N_CLASSES; i++) r_cnt[i] <= '0;
            r_event_cnt <= '0;
            r_timer     <= '0;
            r_class     <= '0;
            r_done      <= 1'b0;
            r_no_winner <= 1'b0;
        end else if (r_state == RUN) begin
            r_timer <= r_timer + 1'b1;
            if (w_hit) begin
                r_cnt[w_cls] <= w_cnt_inc;
                if (r_event_cnt != '1) begin
                    r_event_cnt <= r_event_cnt + 1'b1;
                end
            end
            if (w_win) begin
                r_class <= w_cls;
                r_done  <= 1'b1;
            end else if (w_tmo) begin
                r_class     <= '0;
                r_done      <= 1'b1;
                r_no_winner <= 1'b1;
            end
        end
    end

    assign aer.ack     = r_ack;
    assign o_class_out = r_class;
    assign o_done      = r_done;
    assign o_no_winner = r_no_winner;
    assign o_event_cnt = r_event_cnt;

endmodule

// File: tb/tb_aer_output_decoder.sv
// Directed bench: two decoders (threshold 1 and 3) share one stimulus stream.
// Expected values are hand-computed per step.
module tb_aer_output_decoder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] cls_a;
    logic [3:0] cls_b;
    logic       done_a;
    logic       done_b;
    logic       nw_a;
    logic       nw_b;
    logic [7:0] ev_a;
    logic [7:0] ev_b;
    int         n_tests;
    int         n_fail;

    aer_output_decoder_if #(.ADDR_BITS(8)) link_a ();
    aer_output_decoder_if #(.ADDR_BITS(8)) link_b ();

    aer_output_decoder #(
        .SPIKE_THRESHOLD(1),
        .TIMEOUT_CYCLES (1000)
    ) dut_a (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .aer        (link_a),
        .o_class_out(cls_a),
        .o_done     (done_a),
        .o_no_winner(nw_a),
        .o_event_cnt(ev_a)
    );

    aer_output_decoder #(
        .SPIKE_THRESHOLD(3),
        .TIMEOUT_CYCLES (1000)
    ) dut_b (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .aer        (link_b),
        .o_class_out(cls_b),
        .o_done     (done_b),
        .o_no_winner(nw_b),
        .o_event_cnt(ev_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic r, input logic [7:0] a);
        link_a.req  = r;
        link_b.req  = r;
        link_a.addr = a;
        link_b.addr = a;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // REQ up; ACK must appear on exactly the 3rd edge, then one edge for counting
    task automatic ev_up(input logic [7:0] a);
        set_req(1'b1, a);
        tick(2);
        check("ack_rise_early", {link_a.ack, link_b.ack}, 2'b00);
        tick(1);
        check("ack_rise", {link_a.ack, link_b.ack}, 2'b11);
        tick(1);
    endtask

    task automatic ev_down();
        set_req(1'b0, 8'h00);
        tick(3);
        check("ack_fall", {link_a.ack, link_b.ack}, 2'b00);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        set_req(1'b0, 8'h00);

        // T1 reset
        tick(3);
        check("rst_ack", {link_a.ack, link_b.ack}, 2'b00);
        check("rst_done", {done_a, done_b, nw_a, nw_b}, 4'h0);
        check("rst_cls", {cls_a, cls_b}, 8'h00);
        check("rst_evcnt", {ev_a, ev_b}, 16'h0000);
        rst = 1'b0;
        tick(4);
        check("no_req_ack", {link_a.ack, link_b.ack}, 2'b00);

        // T2 unarmed event: exact ACK latency both ways
        set_req(1'b1, 8'd3);
        tick(2);
        check("t2_ack_2edges", link_a.ack, 1'b0);
        tick(1);
        check("t2_ack_3edges", link_a.ack, 1'b1);
        tick(1);
        set_req(1'b0, 8'd3);
        tick(2);
        check("t2_ackhold_2edges", link_a.ack, 1'b1);
        tick(1);
        check("t2_ackfall_3edges", link_a.ack, 1'b0);
        check("t2_evcnt", {ev_a, ev_b}, 16'h0000);
        check("t2_done", {done_a, done_b}, 2'b00);

        // T3 first-to-spike: 7 wins on dut_a, 2 ignored
        pulse_start();
        set_req(1'b1, 8'd7);
        tick(3);
        check("t3_ack", link_a.ack, 1'b1);
        check("t3_done_before", done_a, 1'b0);
        tick(1);
        check("t3_done_a", done_a, 1'b1);
        check("t3_cls_a", cls_a, 4'd7);
        check("t3_done_b", done_b, 1'b0);
        ev_down();
        ev_up(8'd2);
        ev_down();
        check("t3_cls_a_held", cls_a, 4'd7);
        check("t3_evcnt_a", ev_a, 8'd1);
        check("t3_evcnt_b", ev_b, 8'd2);
        check("t3_nw", {nw_a, nw_b}, 2'b00);

        // T4 threshold 3 on dut_b, address 200 out of range
        pulse_start();
        check("t4_cleared", {done_a, done_b, ev_a, ev_b}, 18'h0);
        ev_up(8'd4);
        ev_down();
        check("t4_a_win", {done_a, cls_a}, {1'b1, 4'd4});
        ev_up(8'd5);
        ev_down();
        ev_up(8'd4);
        ev_down();
        ev_up(8'd200);
        ev_down();
        check("t4_b_oor", ev_b, 8'd3);
        ev_up(8'd5);
        ev_down();
        check("t4_b_5th", done_b, 1'b0);
        ev_up(8'd4);
        ev_down();
        check("t4_b_done", {done_b, nw_b, cls_b}, {1'b1, 1'b0, 4'd4});
        check("t4_b_evcnt", ev_b, 8'd5);
        check("t4_a_evcnt", ev_a, 8'd1);

        // T5 timeout exactly 1000 cycles after the START edge
        pulse_start();
        tick(999);
        check("t5_not_yet", {done_a, done_b}, 2'b00);
        tick(1);
        check("t5_done", {done_a, done_b}, 2'b11);
        check("t5_nw", {nw_a, nw_b}, 2'b11);
        check("t5_cls", {cls_a, cls_b}, 8'h00);
        pulse_start();
        check("t5_restart", {done_a, done_b, nw_a, nw_b}, 4'h0);

        // T6a START coincides with ev_valid: event dropped
        set_req(1'b1, 8'd1);
        tick(3);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("t6_drop_evcnt", {ev_a, ev_b}, 16'h0000);
        check("t6_drop_done", done_a, 1'b0);
        ev_down();

        // address boundary: 10 is out of range, 9 is the last class
        ev_up(8'd10);
        ev_down();
        check("t6_addr10", {ev_a, done_a}, {8'd0, 1'b0});
        ev_up(8'd9);
        ev_down();
        check("t6_addr9_a", {done_a, cls_a, ev_a}, {1'b1, 4'd9, 8'd1});
        check("t6_addr9_b", {done_b, ev_b}, {1'b0, 8'd1});

        // T6b reset mid-handshake, REQ held across release
        set_req(1'b1, 8'd6);
        tick(3);
        check("t6_ack_pre_rst", link_a.ack, 1'b1);
        rst = 1'b1;
        #1;
        check("t6_ack_async", {link_a.ack, link_b.ack}, 2'b00);
        check("t6_rst_outs", {done_a, ev_a}, 9'h0);
        tick(1);
        rst = 1'b0;
        tick(2);
        check("t6_reack_early", link_a.ack, 1'b0);
        tick(1);
        check("t6_reack", {link_a.ack, link_b.ack}, 2'b11);
        tick(1);
        check("t6_idle_evcnt", {ev_a, ev_b, done_a}, 17'h0);
        ev_down();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
